periph_rr_arbiter: RTL



---
 rtl/periph_rr_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/periph_rr_arbiter.sv
// Two-master round-robin arbiter sharing one req/addr_ok/data_ok peripheral slave port.
// Optional WAIT timeout with error response: define PERIPH_ARB_TIMEOUT_EN.
module periph_rr_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MASK_W      = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  input  logic [MASK_W-1:0] m0_wem_i,
  output logic              m0_addr_ok_o,
  output logic              m0_data_ok_o,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_err_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  input  logic [MASK_W-1:0] m1_wem_i,
  output logic              m1_addr_ok_o,
  output logic              m1_data_ok_o,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_err_o,
  output logic              s_req_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_data_o,
  output logic [MASK_W-1:0] s_wem_o,
  input  logic              s_addr_ok_i,
  input  logic              s_data_ok_i,
  input  logic [DATA_W-1:0] s_data_i
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t r_state, w_next;
  logic   r_owner, r_last;
  logic   w_any, w_win, w_accept, w_tmo, w_done;

  assign w_any    = m0_req_i | m1_req_i;
  // on contention the master that did not win last time goes next
  assign w_win    = (m0_req_i & m1_req_i) ? ~r_last : m1_req_i;
  assign w_accept = (r_state == S_IDLE) & w_any & s_addr_ok_i;

`ifdef PERIPH_ARB_TIMEOUT_EN
  localparam int TCNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [TCNT_W-1:0] r_tcnt;

  assign w_tmo = (r_state == S_WAIT) & ~s_data_ok_i & (r_tcnt == TCNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              r_tcnt <= '0;
    else if (w_accept)                       r_tcnt <= '0;
    else if (r_state == S_WAIT && !s_data_ok_i) r_tcnt <= r_tcnt + TCNT_W'(1);
  end
`else
  assign w_tmo = 1'b0;
`endif

  assign w_done = s_data_ok_i | w_tmo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= 1'b0;
      r_last  <= 1'b1;
    end else if (w_accept) begin
      r_owner <= w_win;
      r_last  <= w_win;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_WAIT;
      S_WAIT:  if (w_done)   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // outputs are forced quiet while reset is held, whatever the masters drive
  always_comb begin
    s_req_o      = 1'b0;
    s_we_o       = 1'b0;
    s_addr_o     = '0;
    s_data_o     = '0;
    s_wem_o      = '0;
    m0_addr_ok_o = 1'b0;
    m0_data_ok_o = 1'b0;
    m0_data_o    = '0;
    m0_err_o     = 1'b0;
    m1_addr_ok_o = 1'b0;
    m1_data_ok_o = 1'b0;
    m1_data_o    = '0;
    m1_err_o     = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            s_req_o = 1'b1;
            if (w_win) begin
              s_we_o       = m1_we_i;
              s_addr_o     = m1_addr_i;
              s_data_o     = m1_data_i;
              s_wem_o      = m1_wem_i;
              m1_addr_ok_o = s_addr_ok_i;
            end else begin
              s_we_o       = m0_we_i;
              s_addr_o     = m0_addr_i;
              s_data_o     = m0_data_i;
              s_wem_o      = m0_wem_i;
              m0_addr_ok_o = s_addr_ok_i;
            end
          end
        end
        S_WAIT: begin
          if (r_owner) begin
            m1_data_ok_o = w_done;
            m1_data_o    = s_data_ok_i ? s_data_i : '0;
            m1_err_o     = w_tmo;
          end else begin
            m0_data_ok_o = w_done;
            m0_data_o    = s_data_ok_i ? s_data_i : '0;
            m0_err_o     = w_tmo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
